// File: rtl/shift_reg_ser.sv
// Serial shift engine: parallel-loads an N-bit word on start, shifts it out over N cycles
// in either direction while capturing i_ser_in, then pulses o_done. Optional macro: SHIFT_REG_STALL_EN.
module shift_reg_ser #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic [N-1:0]  i_load_data,
  input  logic          i_dir,
  input  logic          i_ser_in,
`ifdef SHIFT_REG_STALL_EN
  input  logic          i_stall,
`endif
  output logic          o_ser_out,
  output logic [N-1:0]  o_data,
  output logic          o_busy,
  output logic          o_done,
  output logic [CW-1:0] o_bit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e        state_q;
  logic [N-1:0]  data_q;
  logic [N-1:0]  data_d;
  logic          dir_q;
  logic [CW-1:0] idx_q;
  logic          stall_s;
  logic          last_shift_s;

`ifdef SHIFT_REG_STALL_EN
  assign stall_s = i_stall;
`else
  assign stall_s = 1'b0;
`endif

  assign last_shift_s = (idx_q == CW'(N - 1));

  // Next contents of the shift register for one shift in the captured direction.
  always_comb begin
    data_d = data_q;
    if (dir_q) begin
      data_d = {data_q[N-2:0], i_ser_in};
    end else begin
      data_d = {i_ser_in, data_q[N-1:1]};
    end
  end

  // Control FSM, bit counter and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            data_q  <= i_load_data;
            dir_q   <= i_dir;
            idx_q   <= '0;
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          // A stalled cycle freezes data, counter and the visible serial bit.
          if (!stall_s) begin
            data_q <= data_d;
            if (last_shift_s) begin
              idx_q   <= '0;
              state_q <= ST_DONE;
            end else begin
              idx_q   <= idx_q + CW'(1);
              state_q <= ST_SHIFT;
            end
          end else begin
            state_q <= ST_SHIFT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Status decoded straight from the state register so it carries no extra latency.
  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    if (state_q == ST_SHIFT) begin
      o_busy = 1'b1;
    end else if (state_q == ST_DONE) begin
      o_busy = 1'b1;
      o_done = 1'b1;
    end else begin
      o_busy = 1'b0;
      o_done = 1'b0;
    end
  end

  // Serial output shows the bit that leaves on the coming edge; quiet while idle.
  always_comb begin
    o_ser_out = 1'b0;
    if (o_busy) begin
      o_ser_out = dir_q ? data_q[N-1] : data_q[0];
    end else begin
      o_ser_out = 1'b0;
    end
  end

  assign o_data    = data_q;
  assign o_bit_idx = idx_q;

endmodule

// File: tb/tb_shift_reg_ser.sv
// Directed, table-driven bench for shift_reg_ser (N=8) with hand-written corner-case sequences.
module tb_shift_reg_ser;
  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  load_data;
  logic          dir;
  logic          ser_in;
`ifdef SHIFT_REG_STALL_EN
  logic          stall;
`endif
  logic          ser_out;
  logic [N-1:0]  data;
  logic          busy;
  logic          done;
  logic [CW-1:0] bit_idx;

  int checks   = 0;
  int failures = 0;

  shift_reg_ser #(.N(N)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_load_data (load_data),
    .i_dir       (dir),
    .i_ser_in    (ser_in),
`ifdef SHIFT_REG_STALL_EN
    .i_stall     (stall),
`endif
    .o_ser_out   (ser_out),
    .o_data      (data),
    .o_busy      (busy),
    .o_done      (done),
    .o_bit_idx   (bit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] load;
    logic       dir;
    logic [7:0] pat;      // bit k-1 is driven on i_ser_in during SHIFT cycle k
    logic [7:0] exp_ser;  // bit k-1 is the expected o_ser_out in SHIFT cycle k
    logic [7:0] exp_fin;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation: start at edge 0, cycles 1..N shift, N+1 done, N+2 idle.
  task automatic run_op(input int vi);
    start     = 1'b1;
    load_data = vecs[vi].load;
    dir       = vecs[vi].dir;
    tick();
    start     = 1'b0;
    load_data = ~vecs[vi].load;
    dir       = ~vecs[vi].dir;
    for (int k = 1; k <= N; k++) begin
      ser_in = vecs[vi].pat[k-1];
      chk($sformatf("v%0d c%0d busy", vi, k), 32'(busy), 32'd1);
      chk($sformatf("v%0d c%0d done", vi, k), 32'(done), 32'd0);
      chk($sformatf("v%0d c%0d idx", vi, k), 32'(bit_idx), 32'(k - 1));
      chk($sformatf("v%0d c%0d ser_out", vi, k), 32'(ser_out), 32'(vecs[vi].exp_ser[k-1]));
      tick();
    end
    ser_in = 1'b0;
    chk($sformatf("v%0d done pulse", vi), 32'(done), 32'd1);
    chk($sformatf("v%0d done busy", vi), 32'(busy), 32'd1);
    chk($sformatf("v%0d done idx", vi), 32'(bit_idx), 32'd0);
    chk($sformatf("v%0d done data", vi), 32'(data), 32'(vecs[vi].exp_fin));
    tick();
    chk($sformatf("v%0d idle done", vi), 32'(done), 32'd0);
    chk($sformatf("v%0d idle busy", vi), 32'(busy), 32'd0);
    chk($sformatf("v%0d idle ser_out", vi), 32'(ser_out), 32'd0);
    chk($sformatf("v%0d idle data", vi), 32'(data), 32'(vecs[vi].exp_fin));
  endtask

  initial begin
    vecs[0] = '{load: 8'hA5, dir: 1'b0, pat: 8'hFF, exp_ser: 8'hA5, exp_fin: 8'hFF};
    vecs[1] = '{load: 8'h81, dir: 1'b1, pat: 8'h00, exp_ser: 8'h81, exp_fin: 8'h00};
    vecs[2] = '{load: 8'h00, dir: 1'b0, pat: 8'h3C, exp_ser: 8'h00, exp_fin: 8'h3C};
    vecs[3] = '{load: 8'h96, dir: 1'b1, pat: 8'h01, exp_ser: 8'h69, exp_fin: 8'h80};
    vecs[4] = '{load: 8'h96, dir: 1'b0, pat: 8'h01, exp_ser: 8'h96, exp_fin: 8'h01};

    rst_n = 1'b0; start = 1'b0; load_data = 8'h00; dir = 1'b0; ser_in = 1'b0;
`ifdef SHIFT_REG_STALL_EN
    stall = 1'b0;
`endif
    #2;
    chk("reset data", 32'(data), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ser_out", 32'(ser_out), 32'd0);
    chk("reset idx", 32'(bit_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_op(i);
    end

    // Hold: data persists through idle cycles while inputs wiggle.
    for (int i = 0; i < 20; i++) begin
      load_data = 8'($urandom);
      ser_in    = 1'($urandom);
      dir       = 1'($urandom);
      tick();
      chk($sformatf("hold c%0d data", i), 32'(data), 32'h01);
      chk($sformatf("hold c%0d busy", i), 32'(busy), 32'd0);
    end

    // Starts during SHIFT and DONE are ignored; the first one in IDLE is taken.
    start = 1'b1; load_data = 8'h12; dir = 1'b0; ser_in = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      start     = (c == 4);
      load_data = (c == 4) ? 8'hFF : 8'h00;
      if (c == 5) begin
        chk("ign c5 idx", 32'(bit_idx), 32'd4);
        chk("ign c5 data", 32'(data), 32'h01);
      end
      tick();
    end
    start = 1'b0;
    chk("ign c9 done", 32'(done), 32'd1);
    chk("ign c9 data", 32'(data), 32'h00);
    start = 1'b1; load_data = 8'hFF;
    tick();
    chk("ign c10 busy", 32'(busy), 32'd0);
    chk("ign c10 data", 32'(data), 32'h00);
    tick();
    start = 1'b0;
    chk("ign c11 busy", 32'(busy), 32'd1);
    chk("ign c11 idx", 32'(bit_idx), 32'd0);
    chk("ign c11 data", 32'(data), 32'hFF);
    for (int c = 0; c < N + 1; c++) tick();
    chk("ign end busy", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a shift.
    start = 1'b1; load_data = 8'hA5; dir = 1'b1; ser_in = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst data", 32'(data), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst done", 32'(done), 32'd0);
    chk("mid rst ser_out", 32'(ser_out), 32'd0);
    chk("mid rst idx", 32'(bit_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("post rst c%0d busy", c), 32'(busy), 32'd0);
      chk($sformatf("post rst c%0d data", c), 32'(data), 32'd0);
    end

`ifdef SHIFT_REG_STALL_EN
    // Three stalled cycles push the done pulse from cycle 9 to cycle 12.
    start = 1'b1; load_data = 8'hA5; dir = 1'b0; ser_in = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      stall = (c >= 4 && c <= 6);
      chk($sformatf("stall c%0d busy", c), 32'(busy), 32'd1);
      chk($sformatf("stall c%0d done", c), 32'(done), 32'd0);
      if (c >= 4 && c <= 7) begin
        chk($sformatf("stall c%0d idx", c), 32'(bit_idx), 32'd3);
        chk($sformatf("stall c%0d ser_out", c), 32'(ser_out), 32'd0);
      end
      tick();
    end
    stall = 1'b0;
    chk("stall c12 done", 32'(done), 32'd1);
    chk("stall c12 data", 32'(data), 32'hFF);
    tick();
    chk("stall c13 busy", 32'(busy), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
